// File: rtl/item_cart_queue.sv
// item_cart_queue: FIFO cart of validated (item, quantity) selections.
// The head entry is presented on registered outputs and popped on dispense_valid.
// A cart-wide cancel flushes everything and outranks push and pop.
module item_cart_queue #(
    parameter int item_addr     = 10,
    parameter int no_items_addr = 8,
    parameter int item_count    = 1024,
    parameter int cart_depth    = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             select_valid_pulse,
    input  logic [item_addr-1:0]             item_select,
    input  logic [no_items_addr-1:0]         no_items_select,
    input  logic                             dispense_valid,
    input  logic                             cancel,
    output logic [item_addr-1:0]             item_selected,
    output logic [no_items_addr-1:0]         no_items_selected,
    output logic                             head_valid,
    output logic                             selection_done,
    output logic                             select_reject,
    output logic [$clog2(cart_depth+1)-1:0]  cart_count,
    output logic                             cart_full
);

    localparam int ptr_w = (cart_depth > 1) ? $clog2(cart_depth) : 1;
    localparam int cnt_w = $clog2(cart_depth + 1);
    // One extra bit so item_count itself is representable in the range check.
    localparam logic [item_addr:0] item_limit = (item_addr + 1)'(item_count);
    localparam logic [ptr_w-1:0]   ptr_last   = ptr_w'(cart_depth - 1);
    localparam logic [cnt_w-1:0]   cnt_full   = cnt_w'(cart_depth);

    logic [item_addr-1:0]     item_mem [cart_depth];
    logic [no_items_addr-1:0] qty_mem  [cart_depth];

    logic [ptr_w-1:0] wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic [cnt_w-1:0] count_next;
    logic [item_addr-1:0]     head_item_next;
    logic [no_items_addr-1:0] head_qty_next;
    logic pop_ok, sel_ok, room, push_ok, push_rej;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Next-state decode: accept/reject, pointer/count update and new head value.
    always_comb begin
        pop_ok         = dispense_valid && (cart_count != '0);
        sel_ok         = (no_items_select != '0) && ({1'b0, item_select} < item_limit);
        room           = !cart_full || pop_ok;
        push_ok        = select_valid_pulse && sel_ok && room && !cancel;
        push_rej       = select_valid_pulse && !(sel_ok && room) && !cancel;
        wr_ptr_next    = push_ok ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next    = pop_ok  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next     = cart_count;
        if (push_ok && !pop_ok)
            count_next = cart_count + cnt_w'(1);
        else if (!push_ok && pop_ok)
            count_next = cart_count - cnt_w'(1);
        head_item_next = '0;
        head_qty_next  = '0;
        if (count_next != '0) begin
            // The new head is the entry being written this cycle when the cart
            // was (or just became) empty; otherwise it already sits in storage.
            if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
                head_item_next = item_select;
                head_qty_next  = no_items_select;
            end else begin
                head_item_next = item_mem[rd_ptr_next];
                head_qty_next  = qty_mem[rd_ptr_next];
            end
        end
        if (cancel) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            head_item_next = '0;
            head_qty_next  = '0;
        end
    end

    // Entry storage: written only on an accepted push, never modified in place.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            item_mem[wr_ptr_reg] <= item_select;
            qty_mem[wr_ptr_reg]  <= no_items_select;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            cart_count        <= '0;
            cart_full         <= 1'b0;
            head_valid        <= 1'b0;
            item_selected     <= '0;
            no_items_selected <= '0;
            selection_done    <= 1'b0;
            select_reject     <= 1'b0;
        end else begin
            wr_ptr_reg        <= wr_ptr_next;
            rd_ptr_reg        <= rd_ptr_next;
            cart_count        <= count_next;
            cart_full         <= (count_next == cnt_full);
            head_valid        <= (count_next != '0);
            item_selected     <= head_item_next;
            no_items_selected <= head_qty_next;
            selection_done    <= push_ok;
            select_reject     <= push_rej;
        end
    end

endmodule

// File: tb/tb_item_cart_queue.sv
// Scoreboard testbench for item_cart_queue: a queue-based cart model predicts the
// outputs for each driven cycle; a monitor pops and compares after each clock edge.
module tb_item_cart_queue;

    localparam int IA = 10;
    localparam int QA = 8;
    // A reduced item range so out-of-range items are expressible on the 10-bit port.
    localparam int ITEM_COUNT = 1000;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic select_valid_pulse = 1'b0;
    logic [IA-1:0] item_select = '0;
    logic [QA-1:0] no_items_select = '0;
    logic dispense_valid = 1'b0;
    logic cancel = 1'b0;
    logic [IA-1:0] item_selected;
    logic [QA-1:0] no_items_selected;
    logic head_valid, selection_done, select_reject, cart_full;
    logic [CW-1:0] cart_count;

    item_cart_queue #(
        .item_addr(IA), .no_items_addr(QA), .item_count(ITEM_COUNT), .cart_depth(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .select_valid_pulse(select_valid_pulse), .item_select(item_select),
        .no_items_select(no_items_select), .dispense_valid(dispense_valid),
        .cancel(cancel), .item_selected(item_selected),
        .no_items_selected(no_items_selected), .head_valid(head_valid),
        .selection_done(selection_done), .select_reject(select_reject),
        .cart_count(cart_count), .cart_full(cart_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int item;
        int qty;
    } ent_t;

    typedef struct {
        int item;
        int qty;
        int hv;
        int done;
        int rej;
        int cnt;
        int full;
    } exp_t;

    ent_t cart[$];
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: the cart is a plain queue; one call per clock cycle.
    task automatic model_step(input bit r, input bit s, input int it, input int q,
                              input bit d, input bit c);
        exp_t e;
        e.done = 0;
        e.rej  = 0;
        if (!r || c) begin
            cart.delete();
        end else begin
            bit pop_ok;
            pop_ok = d && (cart.size() > 0);
            if (s) begin
                if (q != 0 && it < ITEM_COUNT && (cart.size() < DEPTH || pop_ok))
                    e.done = 1;
                else
                    e.rej = 1;
            end
            if (pop_ok)
                void'(cart.pop_front());
            if (e.done)
                cart.push_back('{item: it, qty: q});
        end
        e.cnt  = cart.size();
        e.full = (cart.size() == DEPTH);
        e.hv   = (cart.size() != 0);
        e.item = (cart.size() != 0) ? cart[0].item : 0;
        e.qty  = (cart.size() != 0) ? cart[0].qty : 0;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and record the prediction.
    task automatic cyc(input bit r, input bit s, input int it, input int q,
                       input bit d, input bit c);
        @(negedge clk);
        rstn               = r;
        select_valid_pulse = s;
        item_select        = IA'(it);
        no_items_select    = QA'(q);
        dispense_valid     = d;
        cancel             = c;
        model_step(r, s, it, q, d, c);
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every predicted cycle just after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("item_selected", int'(item_selected), e.item);
                chk("no_items_selected", int'(no_items_selected), e.qty);
                chk("head_valid", int'(head_valid), e.hv);
                chk("selection_done", int'(selection_done), e.done);
                chk("select_reject", int'(select_reject), e.rej);
                chk("cart_count", int'(cart_count), e.cnt);
                chk("cart_full", int'(cart_full), e.full);
                if (e.done || e.rej)
                    $display("txn t=%0t done=%0d reject=%0d count=%0d head=%0d/%0d",
                             $time, selection_done, select_reject, cart_count,
                             item_selected, no_items_selected);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("reset_head_valid", int'(head_valid), 0);
        chk("reset_count", int'(cart_count), 0);
        chk("reset_item", int'(item_selected), 0);
        idle();
        // push on empty cart
        cyc(1, 1, 5, 3, 0, 0);
        // fill, then overflow reject
        cyc(1, 1, 10, 4, 0, 0);
        cyc(1, 1, 11, 5, 0, 0);
        cyc(1, 1, 12, 6, 0, 0);
        cyc(1, 1, 9, 1, 0, 0);
        // full cart with simultaneous push and pop
        cyc(1, 1, 7, 2, 1, 0);
        idle();
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 0);
        // invalid selections and pop on empty
        cyc(1, 1, 20, 0, 0, 0);
        cyc(1, 1, ITEM_COUNT, 3, 0, 0);
        cyc(1, 1, 1023, 3, 0, 0);
        cyc(1, 1, ITEM_COUNT - 1, 255, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        // cancel with a simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(1, 1, 100 + i, 1 + i, 0, 0);
        cyc(1, 1, 200, 9, 1, 1);
        idle();
        // asynchronous reset mid-stream
        cyc(1, 1, 30, 1, 0, 0);
        cyc(1, 1, 31, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #1;
        chk("async_rst_head_valid", int'(head_valid), 0);
        chk("async_rst_count", int'(cart_count), 0);
        chk("async_rst_item", int'(item_selected), 0);
        chk("async_rst_qty", int'(no_items_selected), 0);
        idle();
        idle();
        // wrap: sustained push+pop keeps FIFO order
        cyc(1, 1, 40, 1, 0, 0);
        cyc(1, 1, 41, 2, 0, 0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 50 + i, 10 + i, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit s, d, c, r;
            int it, q;
            s  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 9) < 4);
            c  = ($urandom_range(0, 49) == 0);
            r  = ($urandom_range(0, 199) != 0);
            it = ($urandom_range(0, 7) == 0) ? $urandom_range(ITEM_COUNT, 1023)
                                             : $urandom_range(0, ITEM_COUNT - 1);
            q  = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
            cyc(r, s, it, q, d, c);
        end
        idle();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
